// File: rtl/scr_shuffle_pkg.sv
// Shared types and helpers for the loop-shuffle permutation generator.
// Holds the FSM state encoding, LFSR constants and the shuffle mask helper.
package scr_shuffle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SHUFFLE,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Smallest all-ones value that covers i, i.e. next power of two minus one.
  function automatic logic [31:0] mask_for(input logic [31:0] i);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 32; b++) begin
      if (m < i) m = {m[30:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/scr_lfsr.sv
// Galois LFSR used as the random source for the Fisher-Yates shuffle.
// A zero seed would lock the register, so it is replaced by SEED on load.
module scr_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_next;

  assign w_next = r_value[0] ? ((r_value >> 1) ^ TAPS) : (r_value >> 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_value <= SEED;
    end else if (load) begin
      r_value <= (seed == '0) ? SEED : seed;
    end else if (en) begin
      r_value <= w_next;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/scr_permutation_gen.sv
// Builds a shuffled permutation table of 0..n-1 (identity fill, then Fisher-Yates)
// and serves it through a registered read port.
module scr_permutation_gen
  import scr_shuffle_pkg::*;
#(
  parameter int                    BITS_PER_ELEMENT = 7,
  parameter int                    LFSR_WIDTH       = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED        = LFSR_WIDTH'(LFSR_SEED_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        seed_valid_i,
  input  logic [LFSR_WIDTH-1:0]       seed_i,
  input  logic                        start_i,
  input  logic [BITS_PER_ELEMENT:0]   num_elements_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        perm_valid_o,
  input  logic [BITS_PER_ELEMENT-1:0] rd_index_i,
  output logic [BITS_PER_ELEMENT-1:0] rd_data_o
);

  localparam int B            = BITS_PER_ELEMENT;
  localparam int NW           = BITS_PER_ELEMENT + 1;
  localparam int MAX_ELEMENTS = 2 ** BITS_PER_ELEMENT;

  state_t r_state, w_next_state;

  logic [NW-1:0]         r_n;
  logic [NW-1:0]         w_n_clamped;
  logic [B-1:0]          r_idx;
  logic [B-1:0]          r_table [MAX_ELEMENTS];
  logic [B-1:0]          r_rd_data;
  logic                  r_perm_valid;
  logic [LFSR_WIDTH-1:0] w_lfsr;
  logic [LFSR_WIDTH-1:0] w_mask;
  logic [LFSR_WIDTH-1:0] w_j_wide;
  logic [B-1:0]          w_j;
  logic                  w_accept_start;
  logic                  w_load_seed;
  logic                  w_lfsr_en;
  logic                  w_fill_we;
  logic                  w_fill_last;
  logic                  w_swap;
  logic                  w_j_ok;

  assign w_n_clamped    = (num_elements_i > NW'(MAX_ELEMENTS)) ? NW'(MAX_ELEMENTS) : num_elements_i;
  assign w_accept_start = (r_state == IDLE) && start_i;
  assign w_load_seed    = (r_state == IDLE) && seed_valid_i;
  assign w_lfsr_en      = (r_state == SHUFFLE);

  // r_idx doubles as the fill counter and the shuffle position i: the fill ends at n-1,
  // which is exactly where the shuffle starts.
  assign w_fill_last = ({1'b0, r_idx} == (r_n - 1'b1));
  assign w_mask      = LFSR_WIDTH'(mask_for(32'(r_idx)));
  assign w_j_wide    = w_lfsr & w_mask;
  assign w_j         = w_j_wide[B-1:0];
  assign w_j_ok      = (w_j_wide <= LFSR_WIDTH'(r_idx));

  scr_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_WIDTH'(LFSR_TAPS))
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load_seed),
    .seed  (seed_i),
    .en    (w_lfsr_en),
    .value (w_lfsr)
  );

  always_comb begin
    w_next_state = r_state;
    w_fill_we    = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) w_next_state = (w_n_clamped == '0) ? DONE : FILL;
      end
      FILL: begin
        w_fill_we = 1'b1;
        if (w_fill_last) w_next_state = (r_n <= NW'(1)) ? DONE : SHUFFLE;
      end
      SHUFFLE: begin
        if (w_j_ok) begin
          w_swap = 1'b1;
          if (r_idx == B'(1)) w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_n          <= '0;
      r_idx        <= '0;
      r_perm_valid <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_state   <= w_next_state;
      r_rd_data <= r_table[rd_index_i];
      if (w_accept_start) begin
        r_n          <= w_n_clamped;
        r_idx        <= '0;
        r_perm_valid <= 1'b0;
      end else if (w_fill_we && !w_fill_last) begin
        r_idx <= r_idx + 1'b1;
      end else if (w_swap) begin
        r_idx <= r_idx - 1'b1;
      end
      if (r_state == DONE) r_perm_valid <= 1'b1;
    end
  end

  // Both swap writes land in the same cycle, hence a flop array rather than a RAM.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_table[r_idx] <= r_idx;
    end else if (w_swap) begin
      r_table[r_idx] <= r_table[w_j];
      r_table[w_j]   <= r_table[r_idx];
    end
  end

  assign busy_o       = (r_state == FILL) || (r_state == SHUFFLE);
  assign done_o       = (r_state == DONE);
  assign perm_valid_o = r_perm_valid;
  assign rd_data_o    = r_rd_data;

endmodule
